// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default baud constants
// and a small helper for sizing counters.
package uart_pkg;

  // Receiver FSM state encoding
  typedef logic [2:0] rx_state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // 50 MHz / (115200 * 16), rounded
  localparam int DEFAULT_BAUD_DIV   = 27;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Larger of two integers, used when sizing shared counters
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running oversample tick generator. Emits a one-cycle tick every
// BAUD_DIV clocks. It is never restarted, so receivers see up to one tick
// of phase error against the incoming start edge.
module baud_tick_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..BAUD_DIV-1 and wrap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver. Reassembles bytes from the rx line, flags
// framing errors, and emits an idle tick after a quiet period following a
// good byte so the downstream packet decoder can realign its boundary.
//
// Handshake: o_rx_done_tick, o_frame_err and o_idle_tick are one-cycle
// pulses with no back-pressure; o_data is valid in the o_rx_done_tick cycle
// and held until the next good byte. The pulses are mutually exclusive.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV     = DEFAULT_BAUD_DIV,
  parameter int OVERSAMPLE   = DEFAULT_OVERSAMPLE,
  parameter int DATA_BIT     = 8,
  parameter int STOP_TICK    = 16,
  parameter int IDLE_TIMEOUT = 160
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_rx,
  output logic [DATA_BIT-1:0] o_data,
  output logic                o_rx_done_tick,
  output logic                o_frame_err,
  output logic                o_busy,
  output logic                o_idle_tick
);

  localparam int S_MAX = max_int(OVERSAMPLE, STOP_TICK);
  localparam int S_W   = $clog2(S_MAX);
  localparam int N_W   = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
  localparam int I_W   = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [S_W-1:0] S_HALF = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [S_W-1:0] S_BIT  = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_STOP = S_W'(STOP_TICK - 1);
  localparam logic [N_W-1:0] N_LAST = N_W'(DATA_BIT - 1);
  localparam logic [I_W-1:0] I_LAST = I_W'(IDLE_TIMEOUT - 1);

  // FSM state; kept as a plainly named register so checkers can bind to it
  rx_state_t           state;
  logic [S_W-1:0]      s_cnt;
  logic [N_W-1:0]      n;
  logic [DATA_BIT-1:0] shreg;
  logic [I_W-1:0]      idle_cnt;
  logic                armed;

  logic                rx_meta;
  logic                rx_s;
  logic                s_tick;

  logic                stop_decide;
  logic                good_stop;
  logic                bad_stop;

  logic [DATA_BIT-1:0] data_q;
  logic                done_q;
  logic                err_q;
  logic                busy_q;
  logic                idle_q;

  baud_tick_gen #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (s_tick)
  );

  // Two-flop synchroniser; the line idles high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  // Stop-bit sample point and its outcome
  assign stop_decide = (state == ST_STOP) && s_tick && (s_cnt == S_STOP);
  assign good_stop   = stop_decide && rx_s;
  assign bad_stop    = stop_decide && !rx_s;

  // Receive FSM: start qualification, mid-bit data sampling, stop check
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      s_cnt <= '0;
      n     <= '0;
      shreg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            s_cnt <= '0;
          end
        end
        ST_START: begin
          if (s_tick) begin
            if (s_cnt == S_HALF) begin
              s_cnt <= '0;
              if (!rx_s) begin
                state <= ST_DATA;
                n     <= '0;
              end else begin
                state <= ST_IDLE;  // too short to be a start bit
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (s_tick) begin
            if (s_cnt == S_BIT) begin
              s_cnt <= '0;
              shreg <= {rx_s, shreg[DATA_BIT-1:1]};
              if (n == N_LAST) begin
                state <= ST_STOP;
              end else begin
                n <= n + 1'b1;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (s_tick) begin
            if (s_cnt == S_STOP) begin
              s_cnt <= '0;
              state <= rx_s ? ST_IDLE : ST_BREAK;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          // A held-low line must release before another start is accepted
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Registered result pulses, held data and busy flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      done_q <= good_stop;
      err_q  <= bad_stop;
      busy_q <= (state != ST_IDLE);
      if (good_stop) begin
        data_q <= shreg;
      end
    end
  end

  // Idle timeout: armed by a good byte, cancelled by any exit from IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      idle_cnt <= '0;
      idle_q   <= 1'b0;
    end else begin
      idle_q <= 1'b0;
      if (good_stop) begin
        armed    <= 1'b1;
        idle_cnt <= '0;
      end else if ((state != ST_IDLE) || !rx_s) begin
        armed    <= 1'b0;
        idle_cnt <= '0;
      end else if (armed && s_tick) begin
        if (idle_cnt == I_LAST) begin
          idle_q   <= 1'b1;
          armed    <= 1'b0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  assign o_data         = data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_err    = err_q;
  assign o_busy         = busy_q;
  assign o_idle_tick    = idle_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with BAUD_DIV=4, OVERSAMPLE=16, so one
// bit lasts 64 clocks and the idle timeout is 640 clocks.
module tb_uart_rx;

  localparam int BIT_CLK  = 64;
  localparam int IDLE_CLK = 640;

  logic       clk;
  logic       rst_n;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done_tick;
  logic       o_frame_err;
  logic       o_busy;
  logic       o_idle_tick;

  int checks   = 0;
  int failures = 0;

  // Expected event queue: bit 8 set = frame error, else good byte in [7:0]
  logic [8:0] exp_q[$];

  // Monitor bookkeeping
  int         cyc           = 0;
  int         last_done_cyc = 0;
  int         idle_delay    = -1;
  int         n_done        = 0;
  int         n_err         = 0;
  int         n_idle        = 0;
  bit         idle_pend     = 1'b0;
  bit         prev_done     = 1'b0;
  bit         exp_idle;
  logic [7:0] model_data    = 8'h00;
  logic [8:0] ev;

  uart_rx #(
    .BAUD_DIV    (4),
    .OVERSAMPLE  (16),
    .DATA_BIT    (8),
    .STOP_TICK   (16),
    .IDLE_TIMEOUT(160)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_rx          (i_rx),
    .o_data        (o_data),
    .o_rx_done_tick(o_rx_done_tick),
    .o_frame_err   (o_frame_err),
    .o_busy        (o_busy),
    .o_idle_tick   (o_idle_tick)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helper ----------------
  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    i_rx = b;
    wait_cycles(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    if (stop) exp_q.push_back({1'b0, d});
    else      exp_q.push_back({1'b1, 8'h00});
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    i_rx = 1'b1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(o_data == 8'h00, {name, "_data"}, o_data, 0);
    chk({o_rx_done_tick, o_frame_err, o_idle_tick, o_busy} == 4'b0000,
        {name, "_flags"}, {o_rx_done_tick, o_frame_err, o_idle_tick, o_busy}, 0);
  endtask

  // ---------------- scoreboard / compare process ----------------
  // Rules: each completed frame produces exactly its queued event; o_data
  // holds the last good byte; busy is high in the done cycle and low the
  // cycle after; an idle tick comes exactly 640 clocks after a good byte
  // when the line has stayed high since; no two pulses coincide.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      model_data = 8'h00;
      idle_pend  = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (i_rx == 1'b0) idle_pend = 1'b0;
      exp_idle = idle_pend && (cyc == last_done_cyc + IDLE_CLK);
      chk(o_idle_tick == exp_idle, "idle_tick", o_idle_tick, exp_idle);
      if (exp_idle) idle_pend = 1'b0;
      if (o_idle_tick) begin
        n_idle++;
        idle_delay = cyc - last_done_cyc;
      end
      chk(int'(o_rx_done_tick) + int'(o_frame_err) + int'(o_idle_tick) <= 1,
          "tick_overlap", {o_rx_done_tick, o_frame_err, o_idle_tick}, 0);
      if (prev_done) chk(o_busy == 1'b0, "busy_fall", o_busy, 0);
      if (o_rx_done_tick) begin
        chk(o_busy == 1'b1, "busy_at_done", o_busy, 1);
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_done", o_data, 0);
        end else begin
          ev = exp_q.pop_front();
          chk(ev[8] == 1'b0 && o_data == ev[7:0], "done_data", {ev[8], o_data}, {1'b0, ev[7:0]});
          model_data = ev[7:0];
        end
        n_done++;
        last_done_cyc = cyc;
        idle_pend     = 1'b1;
      end
      if (o_frame_err) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_frame_err", 1, 0);
        end else begin
          ev = exp_q.pop_front();
          chk(ev[8] == 1'b1, "frame_err_expected", ev, 9'h100);
        end
        n_err++;
      end
      chk(o_data == model_data, "data_hold", o_data, model_data);
      prev_done = o_rx_done_tick;
    end
  end

  // ---------------- stimulus ----------------
  int busy_n;
  int base_done;

  initial begin
    rst_n = 1'b0;
    i_rx  = 1'b1;
    wait_cycles(3);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // No idle tick after reset alone
    wait_cycles(800);
    chk(n_idle == 0, "no_idle_after_reset", n_idle, 0);

    // Single good byte
    send_frame(8'hA5, 1'b1);
    wait_cycles(64);
    chk(o_data == 8'hA5, "a5_data", o_data, 8'hA5);
    chk(n_done == 1, "a5_count", n_done, 1);
    chk(o_busy == 1'b0, "a5_idle_busy", o_busy, 0);

    // Short glitch: 12 clocks low, rejected
    busy_n = 0;
    i_rx = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (i == 12) i_rx = 1'b1;
      @(negedge clk);
      if (o_busy) busy_n++;
    end
    chk(busy_n > 0 && busy_n < 40, "glitch_busy_len", busy_n, 40);
    chk(n_done == 1 && n_err == 0, "glitch_no_event", {n_done[15:0], n_err[15:0]}, 32'h0001_0000);

    // Framing error followed by a held-low line
    send_frame(8'h3C, 1'b0);
    i_rx = 1'b0;
    wait_cycles(128);
    i_rx = 1'b1;
    wait_cycles(200);
    chk(n_err == 1, "ferr_count", n_err, 1);
    chk(n_done == 1, "ferr_no_done", n_done, 1);
    chk(o_data == 8'hA5, "ferr_data_kept", o_data, 8'hA5);
    chk(n_idle == 0, "ferr_no_idle", n_idle, 0);

    // Nine back-to-back frames
    base_done = n_done;
    for (int k = 1; k <= 9; k++) send_frame(8'(k), 1'b1);
    wait_cycles(700);
    chk(n_done - base_done == 9, "burst_count", n_done - base_done, 9);
    chk(o_data == 8'h09, "burst_last", o_data, 8'h09);
    chk(n_idle == 1, "idle_once", n_idle, 1);
    chk(idle_delay == IDLE_CLK, "idle_delay", idle_delay, IDLE_CLK);
    wait_cycles(800);
    chk(n_idle == 1, "idle_no_repeat", n_idle, 1);

    // Reset in the middle of data bit 3 of 0x5A (bits LSB first: 0,1,0,1)
    base_done = n_done;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    i_rx = 1'b1;
    wait_cycles(32);
    chk(o_busy == 1'b1, "abort_busy_before", o_busy, 1);
    rst_n = 1'b0;
    wait_cycles(1);
    chk_all_zero("abort_rst1");
    wait_cycles(1);
    chk_all_zero("abort_rst2");
    rst_n = 1'b1;
    wait_cycles(128);
    chk(n_done == base_done && o_busy == 1'b0, "abort_discarded", n_done - base_done, 0);
    send_frame(8'hC3, 1'b1);
    wait_cycles(64);
    chk(o_data == 8'hC3, "c3_data", o_data, 8'hC3);
    chk(n_done - base_done == 1, "c3_count", n_done - base_done, 1);
    wait_cycles(700);
    chk(n_idle == 2, "c3_idle", n_idle, 2);

    chk(exp_q.size() == 0, "exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
